// File: rtl/timer_pkg.sv
// Shared definitions for the timer control stage: register map, control and
// status bit positions, and the control FSM state type.
package timer_pkg;

   localparam logic [1:0] ADDR_LOAD   = 2'd0;
   localparam logic [1:0] ADDR_RELOAD = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int unsigned CTRL_EN       = 0;
   localparam int unsigned CTRL_PERIODIC = 1;
   localparam int unsigned CTRL_IRQ_EN   = 2;

   localparam int unsigned ST_EXPIRED = 0;
   localparam int unsigned ST_OVERRUN = 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/timer_ctl.sv
// Timer control stage: register-write front end producing countdown
// load/reload commands, plus expiry detection on the returned count.
// Optional build macro: TIMER_CTL_OVERRUN_EN adds STATUS.overrun (bit 1).
module timer_ctl
   import timer_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [1:0]   wr_addr,
   input  logic [W-1:0] wr_data,
   input  logic [1:0]   rd_addr,
   output logic [W-1:0] rd_data,
   input  logic [W-1:0] count,
   output logic [W-1:0] cd_value,
   output logic         cd_put,
   output logic [W-1:0] cd_start,
   output logic         cd_reset,
   output logic         irq
);

   logic [W-1:0] r_reload;
   logic [2:0]   r_ctrl;
   logic         r_expired;
   logic         r_fresh;
   logic [W-1:0] r_rd_data;
   state_t       r_state;
   state_t       w_state_next;

   logic         w_load_wr;
   logic         w_reload_wr;
   logic         w_ctrl_wr;
   logic         w_status_wr;
   logic         w_expire;
   logic [W-1:0] w_status_rd;

`ifdef TIMER_CTL_OVERRUN_EN
   logic         r_overrun;
`endif

   assign w_load_wr   = wr_en && (wr_addr == ADDR_LOAD);
   assign w_reload_wr = wr_en && (wr_addr == ADDR_RELOAD);
   assign w_ctrl_wr   = wr_en && (wr_addr == ADDR_CTRL);
   assign w_status_wr = wr_en && (wr_addr == ADDR_STATUS);

   // The cycle after a load or reload the count is not yet trustworthy, so
   // fresh masks detection; a LOAD write in the zero cycle also pre-empts it.
   assign w_expire = (r_state == S_RUN) && !r_fresh && (count == '0) && !w_load_wr;

   assign cd_start = r_reload;
   assign rd_data  = r_rd_data;
   assign irq      = r_expired & r_ctrl[CTRL_IRQ_EN];

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next state: a CTRL write decides the state outright, otherwise
   // DONE restarts on a LOAD and one-shot RUN ends on expiry
   always_comb begin
      w_state_next = r_state;
      if (w_ctrl_wr) begin
         w_state_next = wr_data[CTRL_EN] ? S_RUN : S_IDLE;
      end else begin
         case (r_state)
            S_DONE:  if (w_load_wr) w_state_next = S_RUN;
            S_RUN:   if (w_expire && !r_ctrl[CTRL_PERIODIC]) w_state_next = S_DONE;
            default: w_state_next = r_state;
         endcase
      end
   end

   // FSM outputs: freeze the countdown outside RUN, LOAD overrides, reload on periodic expiry
   always_comb begin
      cd_put   = 1'b0;
      cd_value = count;
      cd_reset = 1'b0;
      if (reset) begin
         cd_put = 1'b1;
      end else if (w_load_wr) begin
         cd_put   = 1'b1;
         cd_value = wr_data;
      end else if (r_state != S_RUN) begin
         cd_put = 1'b1;
      end else begin
         cd_reset = w_expire & r_ctrl[CTRL_PERIODIC];
      end
   end

   // Register file, expiry flag and the one-cycle fresh mask
   always_ff @(posedge clock) begin
      if (reset) begin
         r_reload  <= '0;
         r_ctrl    <= '0;
         r_expired <= 1'b0;
         r_fresh   <= 1'b0;
      end else begin
         if (w_reload_wr) r_reload <= wr_data;
         if (w_ctrl_wr)   r_ctrl   <= wr_data[2:0];
         if (w_expire)
            r_expired <= 1'b1;
         else if (w_status_wr && wr_data[ST_EXPIRED])
            r_expired <= 1'b0;
         r_fresh <= w_load_wr | cd_reset;
      end
   end

`ifdef TIMER_CTL_OVERRUN_EN
   // Overrun: an expiry lands while the previous one is still unacknowledged
   always_ff @(posedge clock) begin
      if (reset)
         r_overrun <= 1'b0;
      else if (w_expire && r_expired)
         r_overrun <= 1'b1;
      else if (w_status_wr && wr_data[ST_OVERRUN])
         r_overrun <= 1'b0;
   end
`endif

   // STATUS read view with narrow fields zero-extended
   always_comb begin
      w_status_rd             = '0;
      w_status_rd[ST_EXPIRED] = r_expired;
`ifdef TIMER_CTL_OVERRUN_EN
      w_status_rd[ST_OVERRUN] = r_overrun;
`endif
   end

   // Registered read port, one cycle behind rd_addr
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_data <= '0;
      end else begin
         case (rd_addr)
            ADDR_LOAD:   r_rd_data <= count;
            ADDR_RELOAD: r_rd_data <= r_reload;
            ADDR_CTRL:   r_rd_data <= W'(r_ctrl);
            default:     r_rd_data <= w_status_rd;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_ctl.sv
// Bench for timer_ctl with a saturating countdown sibling modelled inline.
// Build with TIMER_CTL_OVERRUN_EN defined to include the overrun sequence.
module tb_timer_ctl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [1:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic [7:0] count;
   logic [7:0] cd_value;
   logic       cd_put;
   logic [7:0] cd_start;
   logic       cd_reset;
   logic       irq;

   logic [7:0] cnt = '0;
   assign count = cnt;

   always #5 clock = ~clock;

   // Countdown sibling: load has priority, then reload, else decrement down to 0 and hold
   always @(posedge clock) begin
      if (cd_put)         cnt <= cd_value;
      else if (cd_reset)  cnt <= cd_start;
      else if (cnt != 0)  cnt <= cnt - 8'd1;
   end

   timer_ctl #(.W(8)) dut (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .count    (count),
      .cd_value (cd_value),
      .cd_put   (cd_put),
      .cd_start (cd_start),
      .cd_reset (cd_reset),
      .irq      (irq)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state; mode: 0 idle, 1 running, 2 done
   int m_cnt = 0, m_reload = 0, m_ctrl = 0, m_exp = 0, m_mode = 0, m_fresh = 0, m_rd = 0;
`ifdef TIMER_CTL_OVERRUN_EN
   int m_ovr = 0;
`endif

   // Pre-edge strobes of the last step, for hand-written checks
   int s_reset = 0, s_val = 0, s_put = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check strobes, clock, check registered results
   task automatic step(input bit rst, input bit we, input int a, input int d, input int ra);
      int load, expire, per, creset, put, val, n_rd;
      reset   = rst;
      wr_en   = we;
      wr_addr = a[1:0];
      wr_data = d[7:0];
      rd_addr = ra[1:0];
      #1;
      load   = (we && a == 0) ? 1 : 0;
      per    = (m_ctrl >> 1) & 1;
      expire = (!rst && m_mode == 1 && m_fresh == 0 && m_cnt == 0 && load == 0) ? 1 : 0;
      creset = (!rst && load == 0 && expire == 1 && per == 1) ? 1 : 0;
      put    = (rst || load == 1 || m_mode != 1) ? 1 : 0;
      val    = (load == 1 && !rst) ? d : m_cnt;
      check("cd_put", cd_put, put);
      if (put == 1) check("cd_value", cd_value, val);
      check("cd_reset", cd_reset, creset);
      check("irq_pre", irq, m_exp & ((m_ctrl >> 2) & 1));
      s_reset = cd_reset;
      s_val   = cd_value;
      s_put   = cd_put;
      @(posedge clock);
      case (ra)
         0: n_rd = m_cnt;
         1: n_rd = m_reload;
         2: n_rd = m_ctrl;
         default: begin
            n_rd = m_exp;
`ifdef TIMER_CTL_OVERRUN_EN
            n_rd = n_rd + 2 * m_ovr;
`endif
         end
      endcase
      if (put == 1)       m_cnt = val;
      else if (creset == 1) m_cnt = m_reload;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
      if (rst) begin
         m_reload = 0; m_ctrl = 0; m_exp = 0; m_mode = 0; m_fresh = 0; m_rd = 0;
`ifdef TIMER_CTL_OVERRUN_EN
         m_ovr = 0;
`endif
      end else begin
         m_rd = n_rd;
`ifdef TIMER_CTL_OVERRUN_EN
         if (expire == 1 && m_exp == 1) m_ovr = 1;
         else if (we && a == 3 && ((d >> 1) & 1) == 1) m_ovr = 0;
`endif
         if (expire == 1) m_exp = 1;
         else if (we && a == 3 && (d & 1) == 1) m_exp = 0;
         if (we && a == 2)                 m_mode = d & 1;
         else if (m_mode == 2 && load == 1) m_mode = 1;
         else if (expire == 1 && per == 0)  m_mode = 2;
         if (we && a == 1) m_reload = d & 255;
         if (we && a == 2) m_ctrl = d & 7;
         m_fresh = (load == 1 || creset == 1) ? 1 : 0;
      end
      #1;
      check("count", count, m_cnt);
      check("rd_data", rd_data, m_rd);
      check("irq", irq, m_exp & ((m_ctrl >> 2) & 1));
      check("cd_start", cd_start, m_reload);
      @(negedge clock);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit we;
      int a;
      int d;
      int ra;
      int cnt;
      int irq;
      int rd;
   } vec_t;

   vec_t tbl[11];

   initial begin
      // One-shot run from 5: rows are {we, addr, data, rd_addr, count, irq, rd_data}
      tbl[0]  = '{1'b1, 0, 5, 2, 5, 0, 0};
      tbl[1]  = '{1'b1, 2, 1, 0, 5, 0, 5};
      tbl[2]  = '{1'b0, 0, 0, 0, 4, 0, 5};
      tbl[3]  = '{1'b0, 0, 0, 0, 3, 0, 4};
      tbl[4]  = '{1'b0, 0, 0, 0, 2, 0, 3};
      tbl[5]  = '{1'b0, 0, 0, 0, 1, 0, 2};
      tbl[6]  = '{1'b0, 0, 0, 0, 0, 0, 1};
      tbl[7]  = '{1'b0, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{1'b0, 0, 0, 3, 0, 0, 1};
      tbl[9]  = '{1'b0, 0, 0, 3, 0, 0, 1};
      tbl[10] = '{1'b0, 0, 0, 2, 0, 0, 1};

      @(negedge clock);
      do_reset();
      check("reset rd_data", rd_data, 0);
      check("reset irq", irq, 0);
      check("reset cd_put", cd_put, 1);

      for (int i = 0; i < 11; i++) begin
         step(0, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].ra);
         check($sformatf("oneshot[%0d] count", i), count, tbl[i].cnt);
         check($sformatf("oneshot[%0d] irq", i), irq, tbl[i].irq);
         check($sformatf("oneshot[%0d] rd", i), rd_data, tbl[i].rd);
      end

      // Periodic, RELOAD=3: expiry every 4 cycles, W1C drops irq
      do_reset();
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 3, 0);
      step(0, 1, 2, 7, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      check("periodic count before expiry", count, 0);
      check("periodic irq before expiry", irq, 0);
      step(0, 0, 0, 0, 0);
      check("periodic first expiry irq", irq, 1);
      check("periodic first reload strobe", s_reset, 1);
      check("periodic reload count", count, 3);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      check("periodic mid count", count, 0);
      step(0, 0, 0, 0, 0);
      check("periodic second reload strobe", s_reset, 1);
      check("periodic second reload count", count, 3);
      step(0, 1, 3, 1, 0);
      check("w1c irq drop", irq, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("irq low before next expiry", irq, 0);
      step(0, 0, 0, 0, 0);
      check("irq rises at next expiry", irq, 1);

      // Disable while running freezes the count after the in-flight decrement
      do_reset();
      step(0, 1, 0, 9, 0);
      step(0, 1, 2, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("count at 7", count, 7);
      step(0, 1, 2, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 0, 0, 0);
         check($sformatf("frozen[%0d]", i), count, 6);
      end
      step(0, 1, 2, 1, 0);
      check("resume write cycle", count, 6);
      step(0, 0, 0, 0, 0);
      check("resume 5", count, 5);
      step(0, 0, 0, 0, 0);
      check("resume 4", count, 4);

      // LOAD in the expiry cycle wins
      do_reset();
      step(0, 1, 1, 5, 0);
      step(0, 1, 0, 2, 0);
      step(0, 1, 2, 3, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("load race count 0", count, 0);
      step(0, 1, 0, 9, 3);
      check("load race cd_reset", s_reset, 0);
      check("load race cd_put", s_put, 1);
      check("load race cd_value", s_val, 9);
      check("load race count", count, 9);
      step(0, 0, 0, 0, 3);
      check("load race no expiry", rd_data, 0);

      // Reset mid-run freezes count and clears registers
      do_reset();
      step(0, 1, 0, 6, 0);
      step(0, 1, 2, 7, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("pre-reset count", count, 4);
      step(1, 0, 0, 0, 2);
      check("mid reset count", count, 4);
      check("mid reset irq", irq, 0);
      check("mid reset cd_value", s_val, 4);
      step(0, 0, 0, 0, 2);
      check("post reset ctrl", rd_data, 0);
      check("post reset count", count, 4);
      step(0, 0, 0, 0, 1);
      check("post reset reload", rd_data, 0);

`ifdef TIMER_CTL_OVERRUN_EN
      // Second unacknowledged expiry sets overrun; W1C of bit1 alone
      do_reset();
      step(0, 1, 1, 2, 0);
      step(0, 1, 0, 2, 0);
      step(0, 1, 2, 3, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 3, 2, 3);
      check("overrun status", rd_data, 3);
      step(0, 0, 0, 0, 3);
      check("overrun cleared", rd_data, 1);
`endif

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         bit rst, we;
         int a, d, ra;
         rst = ($urandom_range(0, 99) == 0);
         we  = ($urandom_range(0, 2) == 0);
         a   = $urandom_range(0, 3);
         ra  = $urandom_range(0, 3);
         case (a)
            2:       d = $urandom_range(0, 7);
            3:       d = $urandom_range(0, 3);
            default: d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
         endcase
         step(rst, we, a, d, ra);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
